// File: rtl/dcnn_param_loader.sv
// Loader for the CNN/FC/IMG parameter regions: arbitrates reloads, issues one burst per region and
// writes returned words through one output register. Option macro: DCNN_LOADER_CHECKSUM_EN.
module dcnn_param_loader #(
  parameter int unsigned DW        = 16,
  parameter int unsigned CNN_WORDS = 50704,
  parameter int unsigned FC_WORDS  = 11218,
  parameter int unsigned IMG_WORDS = 1024,
  parameter int unsigned AW        = $clog2((CNN_WORDS > FC_WORDS)
      ? ((CNN_WORDS > IMG_WORDS) ? CNN_WORDS : IMG_WORDS)
      : ((FC_WORDS > IMG_WORDS) ? FC_WORDS : IMG_WORDS))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          loadCNN,
  input  logic          loadFC,
  input  logic          loadImg,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [1:0]    req_ch,
  output logic [AW:0]   req_len,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          dst_we,
  output logic [1:0]    dst_sel,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  input  logic          dst_ready,
  output logic          finishCNN,
  output logic          finishFC,
  output logic          finishImg,
  output logic          done,
  output logic [2:0]    chk_err
);

`ifdef DCNN_LOADER_CHECKSUM_EN
  localparam int unsigned Trl = 1;
`else
  localparam int unsigned Trl = 0;
`endif
  localparam logic [AW:0] CnnLen = (AW+1)'(CNN_WORDS + Trl);
  localparam logic [AW:0] FcLen  = (AW+1)'(FC_WORDS + Trl);
  localparam logic [AW:0] ImgLen = (AW+1)'(IMG_WORDS + Trl);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StFin} state_e;

  state_e      state;
  logic [2:0]  pending, finish, load, load_eff, act_oh, ch_oh, pick_oh, pend_clr;
  logic [1:0]  ch, pick;
  logic [AW:0] cnt, len, pick_len;
  logic        any_pend, accept, drained, wr_word;

  assign load      = {loadImg, loadFC, loadCNN};
  assign any_pend  = |pending;
  assign ch_oh     = 3'b001 << ch;
  assign pick_oh   = 3'b001 << pick;
  assign drained   = !dst_we || dst_ready;
  assign src_ready = (state == StStream) && (cnt < len) && drained;
  assign accept    = src_valid && src_ready;
  assign {finishImg, finishFC, finishCNN} = finish;

  // The region being started in IDLE already counts as active, so its pulse is dropped.
  assign act_oh   = (state != StIdle) ? ch_oh : (any_pend ? pick_oh : 3'b000);
  assign load_eff = load & ~act_oh;
  assign pend_clr = (state == StIdle && any_pend) ? pick_oh : 3'b000;

  always_comb begin
    pick     = 2'd2;
    pick_len = ImgLen;
    if (pending[0]) begin
      pick     = 2'd0;
      pick_len = CnnLen;
    end else if (pending[1]) begin
      pick     = 2'd1;
      pick_len = FcLen;
    end
  end

`ifdef DCNN_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum;
  assign wr_word = (cnt + 1'b1) < len;
`else
  assign wr_word = 1'b1;
  assign chk_err = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      pending   <= 3'b000;
      finish    <= 3'b000;
      done      <= 1'b0;
      ch        <= 2'd0;
      cnt       <= '0;
      len       <= '0;
      req_valid <= 1'b0;
      req_ch    <= 2'd0;
      req_len   <= '0;
      dst_we    <= 1'b0;
      dst_sel   <= 2'd0;
      dst_addr  <= '0;
      dst_data  <= '0;
`ifdef DCNN_LOADER_CHECKSUM_EN
      sum       <= '0;
      chk_err   <= 3'b000;
`endif
    end else begin
      pending <= (pending & ~pend_clr) | load_eff;
      done    <= &finish;
      if (dst_we && dst_ready) dst_we <= 1'b0;
      unique case (state)
        StIdle: begin
          if (any_pend) begin
            ch        <= pick;
            len       <= pick_len;
            req_ch    <= pick;
            req_len   <= pick_len;
            req_valid <= 1'b1;
            finish    <= finish & ~pick_oh;
            done      <= 1'b0;
`ifdef DCNN_LOADER_CHECKSUM_EN
            sum       <= '0;
            chk_err   <= chk_err & ~pick_oh;
`endif
            state     <= StReq;
          end
        end
        StReq: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            cnt       <= '0;
            state     <= StStream;
          end
        end
        StStream: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (wr_word) begin
              dst_we   <= 1'b1;
              dst_sel  <= ch;
              dst_addr <= cnt[AW-1:0];
              dst_data <= src_data;
`ifdef DCNN_LOADER_CHECKSUM_EN
              sum      <= sum + src_data;
            end else if (src_data != sum) begin
              chk_err  <= chk_err | ch_oh;
`endif
            end
          end else if (cnt == len && drained) begin
            state <= StFin;
          end
        end
        StFin: begin
          finish <= finish | ch_oh;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcnn_param_loader.sv
// Directed bench for dcnn_param_loader with a reduced CNN region; a monitor checks every write
// (address, data, region, hold-while-stalled) against the source pattern.
module tb_dcnn_param_loader;
  localparam int DW = 16, CNN_N = 300, FC_N = 11218, IMG_N = 1024, AW = 14;
`ifdef DCNN_LOADER_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic loadCNN = 1'b0, loadFC = 1'b0, loadImg = 1'b0;
  logic req_valid, req_ready = 1'b1;
  logic [1:0] req_ch;
  logic [AW:0] req_len;
  logic src_valid = 1'b1, src_ready;
  logic [DW-1:0] src_data;
  logic dst_we, dst_ready = 1'b1;
  logic [1:0] dst_sel;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_data;
  logic finishCNN, finishFC, finishImg, done;
  logic [2:0] chk_err, fin_vec;

  dcnn_param_loader #(.DW(DW), .CNN_WORDS(CNN_N), .FC_WORDS(FC_N), .IMG_WORDS(IMG_N)) dut (
    .clk(clk), .rst_n(rst_n), .loadCNN(loadCNN), .loadFC(loadFC), .loadImg(loadImg),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_len(req_len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dst_we(dst_we), .dst_sel(dst_sel), .dst_addr(dst_addr), .dst_data(dst_data),
    .dst_ready(dst_ready), .finishCNN(finishCNN), .finishFC(finishFC), .finishImg(finishImg),
    .done(done), .chk_err(chk_err)
  );

  always #5 clk = ~clk;
  assign fin_vec = {finishImg, finishFC, finishCNN};

  int errors = 0, checks = 0;
  bit ones_mode = 1'b0, rand_en = 1'b0;
  logic [15:0] trailer = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nwords(input logic [1:0] c);
    return (c == 2'd0) ? CNN_N : (c == 2'd1) ? FC_N : IMG_N;
  endfunction

  function automatic logic [15:0] pat(input logic [1:0] c, input int k, input bit ones);
    logic [15:0] kk;
    kk = 16'(k);
    case (c)
      2'd0:    return kk ^ 16'hA5A5;
      2'd1:    return kk ^ 16'h5A5A;
      default: return ones ? 16'd1 : kk;
    endcase
  endfunction

  // Upstream word source: restarts at word 0 on each accepted burst request.
  logic [1:0] src_ch;
  int src_idx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ch  <= 2'd0;
      src_idx <= 0;
    end else if (req_valid && req_ready) begin
      src_ch  <= req_ch;
      src_idx <= 0;
    end else if (src_valid && src_ready) begin
      src_idx <= src_idx + 1;
    end
  end
  assign src_data = (src_idx == nwords(src_ch)) ? trailer : pat(src_ch, src_idx, ones_mode);

  always @(negedge clk) dst_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;

  logic [1:0] exp_ord [32];
  int n_push = 0;
  initial for (int i = 0; i < 32; i++) exp_ord[i] = 2'd3;

  task automatic push(input logic [1:0] c);
    exp_ord[n_push] = c;
    n_push++;
  endtask

  int wr_cnt = 0, bad_wr = 0, hs_cnt = 0, mon_idx = 0;
  logic [1:0] mon_ch = 2'd0, p_sel = 2'd0;
  logic p_we = 1'b0, p_rdy = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      p_we = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        check("req_ch", 32'(req_ch), 32'(exp_ord[hs_cnt]));
        check("req_len", 32'(req_len), 32'(nwords(exp_ord[hs_cnt]) + TRL));
        mon_ch  = exp_ord[hs_cnt];
        mon_idx = 0;
        hs_cnt++;
      end
      if (p_we && !p_rdy && !(dst_we && dst_addr == p_addr && dst_data == p_data
                               && dst_sel == p_sel)) bad_wr++;
      if (dst_we && dst_ready) begin
        if (dst_addr != AW'(mon_idx) || dst_data != pat(mon_ch, mon_idx, ones_mode)
            || dst_sel != mon_ch) bad_wr++;
        mon_idx++;
        wr_cnt++;
      end
      p_we = dst_we; p_rdy = dst_ready; p_addr = dst_addr; p_data = dst_data; p_sel = dst_sel;
    end
  end

  task automatic pulse(input logic [2:0] m);
    {loadImg, loadFC, loadCNN} = m;
    @(negedge clk);
    {loadImg, loadFC, loadCNN} = 3'b000;
  endtask

  task automatic wait_fin(input string tag, input int b, input logic val, input int limit);
    int i = 0;
    while (fin_vec[b] !== val && i < limit) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(fin_vec[b]), 32'(val));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(req_valid), 0);
    check({tag, "_src_ready"}, 32'(src_ready), 0);
    check({tag, "_dst_we"}, 32'(dst_we), 0);
    check({tag, "_dst_addr"}, 32'(dst_addr), 0);
    check({tag, "_dst_data"}, 32'(dst_data), 0);
    check({tag, "_finish"}, 32'(fin_vec), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_chk_err"}, 32'(chk_err), 0);
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, bbase, hs0, i;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single IMG load
    base = wr_cnt; bbase = bad_wr;
    push(2'd2);
    pulse(3'b100);
    wait_fin("t1_img", 2, 1'b1, 5000);
    check("t1_writes", 32'(wr_cnt - base), 32'(IMG_N));
    check("t1_bad", 32'(bad_wr - bbase), 0);
    check("t1_done", 32'(done), 0);
    check("t1_cnn", 32'(finishCNN), 0);
    check("t1_src_idle", 32'(src_ready), 0);

    // All three at once: CNN, FC, IMG order, done one cycle after finishImg
    base = wr_cnt; bbase = bad_wr;
    push(2'd0); push(2'd1); push(2'd2);
    pulse(3'b111);
    wait_fin("t2_img_drop", 2, 1'b0, 20000);
    wait_fin("t2_img_rise", 2, 1'b1, 5000);
    check("t2_done_pre", 32'(done), 0);
    @(negedge clk);
    check("t2_done_post", 32'(done), 1);
    check("t2_writes", 32'(wr_cnt - base), 32'(CNN_N + FC_N + IMG_N));
    check("t2_bad", 32'(bad_wr - bbase), 0);

    // FC reload with a stalling destination
    base = wr_cnt; bbase = bad_wr;
    rand_en = 1'b1;
    push(2'd1);
    pulse(3'b010);
    wait_fin("t3_fc_drop", 1, 1'b0, 10);
    check("t3_done_drop", 32'(done), 0);
    check("t3_others", 32'({finishImg, finishCNN}), 32'(2'b11));
    wait_fin("t3_fc_rise", 1, 1'b1, 60000);
    rand_en = 1'b0;
    check("t3_writes", 32'(wr_cnt - base), 32'(FC_N));
    check("t3_bad", 32'(bad_wr - bbase), 0);
    @(negedge clk);
    check("t3_done", 32'(done), 1);

    // Reset in the middle of an FC burst, then restart
    base = wr_cnt;
    push(2'd1);
    pulse(3'b010);
    i = 0;
    while (wr_cnt - base < 500 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("t4_reach500", 32'(wr_cnt - base >= 500), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_cnt; bbase = bad_wr;
    push(2'd1);
    pulse(3'b010);
    wait_fin("t4_fc", 1, 1'b1, 20000);
    check("t4_writes", 32'(wr_cnt - base), 32'(FC_N));
    check("t4_bad", 32'(bad_wr - bbase), 0);
    push(2'd0); push(2'd2);
    pulse(3'b101);
    wait_fin("t4_img", 2, 1'b1, 5000);
    check("t4_cnn", 32'(finishCNN), 1);
    @(negedge clk);
    check("t4_done", 32'(done), 1);

    // CNN reload with a second pulse mid-stream
    base = wr_cnt; bbase = bad_wr; hs0 = hs_cnt;
    push(2'd0);
    pulse(3'b001);
    wait_fin("t5_cnn_drop", 0, 1'b0, 10);
    check("t5_done_drop", 32'(done), 0);
    repeat (20) @(negedge clk);
    pulse(3'b001);
    wait_fin("t5_cnn_rise", 0, 1'b1, 2000);
    check("t5_writes", 32'(wr_cnt - base), 32'(CNN_N));
    check("t5_bad", 32'(bad_wr - bbase), 0);
    @(negedge clk);
    check("t5_done", 32'(done), 1);
    repeat (10) @(negedge clk);
    check("t5_bursts", 32'(hs_cnt - hs0), 1);
    check("t5_req_idle", 32'(req_valid), 0);

`ifdef DCNN_LOADER_CHECKSUM_EN
    // IMG checksum: correct trailer, then wrong trailer
    ones_mode = 1'b1;
    trailer = 16'h0400;
    base = wr_cnt;
    push(2'd2);
    pulse(3'b100);
    wait_fin("t6a_drop", 2, 1'b0, 10);
    wait_fin("t6a_rise", 2, 1'b1, 5000);
    check("t6a_chk", 32'(chk_err[2]), 0);
    check("t6a_writes", 32'(wr_cnt - base), 32'(IMG_N));
    trailer = 16'h0401;
    base = wr_cnt;
    push(2'd2);
    pulse(3'b100);
    wait_fin("t6b_drop", 2, 1'b0, 10);
    wait_fin("t6b_rise", 2, 1'b1, 5000);
    check("t6b_chk", 32'(chk_err[2]), 1);
    check("t6b_writes", 32'(wr_cnt - base), 32'(IMG_N));
    ones_mode = 1'b0;
`endif

    check("bursts_total", 32'(hs_cnt), 32'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
